// File: rtl/hc4x_pkg.sv
// Shared definitions for the hc4x stack core: FSM encoding, opcode fields,
// ALU selects and jump-condition codes.
package hc4x_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2
    } state_t;

    // ir[7:5] major opcodes (0xx is store, 11x is jump)
    localparam logic [2:0] OP_LDM = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;

    // ir[6:4] store data select
    localparam logic [2:0] ALU_C   = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_NOT = 3'd6;
    localparam logic [2:0] ALU_A   = 3'd7;

    // ir[2:0] jump conditions (anything else is a NOP)
    localparam logic [2:0] JC_JP  = 3'd0;
    localparam logic [2:0] JC_NOP = 3'd1;
    localparam logic [2:0] JC_C   = 3'd2;
    localparam logic [2:0] JC_NC  = 3'd3;
    localparam logic [2:0] JC_Z   = 3'd4;
    localparam logic [2:0] JC_NZ  = 3'd5;

    function automatic logic jump_taken(input logic [2:0] cc, input logic carry, input logic zero);
        case (cc)
            JC_JP:   return 1'b1;
            JC_C:    return carry;
            JC_NC:   return !carry;
            JC_Z:    return zero;
            JC_NZ:   return !zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hc4x_if.sv
// Instruction and data memory bus of the hc4x core.
interface hc4x_if #(
    parameter int DATA_W = 4
);
    localparam int PC_W   = 3*DATA_W;
    localparam int ADDR_W = 2*DATA_W;

    logic [PC_W-1:0]   imem_addr;
    logic              imem_req;
    logic [7:0]        imem_data;
    logic              imem_valid;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_rd;
    logic              dmem_wr;
    logic              dmem_ready;

    modport master (
        output imem_addr, imem_req, dmem_addr, dmem_wdata, dmem_rd, dmem_wr,
        input  imem_data, imem_valid, dmem_rdata, dmem_ready
    );

    modport slave (
        input  imem_addr, imem_req, dmem_addr, dmem_wdata, dmem_rd, dmem_wr,
        output imem_data, imem_valid, dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/hc4x_alu.sv
// Store-data ALU: purely combinational, carry only meaningful for ADD/SUB.
module hc4x_alu
    import hc4x_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [2:0]        sel_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] c_i,
    output logic [DATA_W-1:0] res_o,
    output logic              carry_o
);
    logic [DATA_W:0] sum;

    // Select the store word; SUB carry means "no borrow" (A >= B)
    always_comb begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        res_o   = '0;
        carry_o = 1'b0;
        case (sel_i)
            ALU_C:   res_o = c_i;
            ALU_ADD: begin
                res_o   = sum[DATA_W-1:0];
                carry_o = sum[DATA_W];
            end
            ALU_SUB: begin
                res_o   = a_i - b_i;
                carry_o = (a_i >= b_i);
            end
            ALU_AND: res_o = a_i & b_i;
            ALU_OR:  res_o = a_i | b_i;
            ALU_XOR: res_o = a_i ^ b_i;
            ALU_NOT: res_o = ~a_i;
            default: res_o = a_i;
        endcase
    end
endmodule

// File: rtl/hc4x_core.sv
// hc4x stack core: FETCH/EXEC/MEM sequencer, operand stack, flags and pc.
module hc4x_core
    import hc4x_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int STACK_DEPTH = 3
) (
    input  logic                          clk,
    input  logic                          nReset,
    input  logic                          halt,
    hc4x_if.master                        bus,
    output logic [STACK_DEPTH*DATA_W-1:0] stack_out,
    output logic [3*DATA_W-1:0]           pc_out,
    output logic [1:0]                    flags_out,
    output logic [1:0]                    state_out
);
    localparam int PC_W   = 3*DATA_W;
    localparam int ADDR_W = 2*DATA_W;

    state_t                                state_q;
    logic [PC_W-1:0]                       pc_q;
    logic [7:0]                            ir_q;
    logic [STACK_DEPTH-1:0][DATA_W-1:0]    stk_q;
    logic                                  carry_q;
    logic                                  zero_q;
    logic                                  rd_q;
    logic                                  wr_q;
    logic [ADDR_W-1:0]                     daddr_q;
    logic [DATA_W-1:0]                     wdata_q;

    logic [DATA_W-1:0] stk_a, stk_b, stk_c;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [ADDR_W-1:0] addr_d;
    logic [PC_W-1:0]   pc_inc;
    logic              fetch_req;

    assign stk_a = stk_q[0];
    assign stk_b = stk_q[1];
    assign stk_c = stk_q[2];

    // Stack is untouched while in MEM, so the ALU output stays valid there too
    hc4x_alu #(.DATA_W(DATA_W)) u_alu (
        .sel_i   (ir_q[6:4]),
        .a_i     (stk_a),
        .b_i     (stk_b),
        .c_i     (stk_c),
        .res_o   (alu_res),
        .carry_o (alu_carry)
    );

    // ir[6:4]==000 addresses through {B,A}, everything else uses the short form
    assign addr_d    = (ir_q[6:4] == 3'b000) ? {stk_b, stk_a} : {{(ADDR_W-4){1'b0}}, ir_q[3:0]};
    assign pc_inc    = pc_q + PC_W'(1);
    // Request is gated by reset so no strobe is visible while nReset is low
    assign fetch_req = (state_q == ST_FETCH) && !halt && nReset;

    // Sequencer and all architectural state; reset aborts any access at once
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            stk_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            daddr_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (fetch_req && bus.imem_valid) begin
                        ir_q    <= bus.imem_data;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!ir_q[7]) begin
                        daddr_q <= addr_d;
                        wdata_q <= alu_res;
                        wr_q    <= 1'b1;
                        state_q <= ST_MEM;
                    end else if (ir_q[7:5] == OP_LDM) begin
                        daddr_q <= addr_d;
                        rd_q    <= 1'b1;
                        state_q <= ST_MEM;
                    end else if (ir_q[7:5] == OP_LDI) begin
                        stk_q   <= {stk_q[STACK_DEPTH-2:0], {(DATA_W-4){1'b0}}, ir_q[3:0]};
                        pc_q    <= pc_inc;
                        state_q <= ST_FETCH;
                    end else begin
                        pc_q    <= jump_taken(ir_q[2:0], carry_q, zero_q) ? {stk_c, stk_b, stk_a} : pc_inc;
                        state_q <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (bus.dmem_ready) begin
                        if (wr_q) begin
                            zero_q <= (wdata_q == '0);
                            if (ir_q[6:4] == ALU_ADD || ir_q[6:4] == ALU_SUB)
                                carry_q <= alu_carry;
                        end else begin
                            stk_q <= {stk_q[STACK_DEPTH-2:0], bus.dmem_rdata};
                        end
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        pc_q    <= pc_inc;
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.imem_req   = fetch_req;
    assign bus.dmem_addr  = daddr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.dmem_rd    = rd_q;
    assign bus.dmem_wr    = wr_q;

    assign stack_out = stk_q;
    assign pc_out    = pc_q;
    assign flags_out = {carry_q, zero_q};
    assign state_out = state_q;
endmodule

// File: tb/tb_hc4x_core.sv
// Bench for hc4x_core: directed scenarios plus random instructions checked
// against an instruction-level model (4-bit/4-deep core), and an 8-bit core
// for the wide {B,A} load.
module tb_hc4x_core;
    logic clk = 1'b0;
    logic nReset, halt, halt8;

    logic [15:0] stack_out;
    logic [11:0] pc_out;
    logic [1:0]  flags_out, state_out;
    logic [23:0] stack8, pc8;
    logic [1:0]  flags8, state8;

    hc4x_if #(.DATA_W(4)) bus ();
    hc4x_if #(.DATA_W(8)) bus8 ();

    int errors = 0;
    int checks = 0;

    // instruction-level model state
    int m_stk [4];
    int m_pc, m_c, m_z;
    int seen_hi, seen_addr, seen_wd;

    always #5 clk = ~clk;

    hc4x_core #(.DATA_W(4), .STACK_DEPTH(4)) u_dut (
        .clk(clk), .nReset(nReset), .halt(halt), .bus(bus),
        .stack_out(stack_out), .pc_out(pc_out), .flags_out(flags_out), .state_out(state_out)
    );

    hc4x_core #(.DATA_W(8), .STACK_DEPTH(3)) u_dut8 (
        .clk(clk), .nReset(nReset), .halt(halt8), .bus(bus8),
        .stack_out(stack8), .pc_out(pc8), .flags_out(flags8), .state_out(state8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 0; m_c = 0; m_z = 0;
        for (int i = 0; i < 4; i++) m_stk[i] = 0;
    endtask

    task automatic m_push(input int v);
        for (int i = 3; i > 0; i--) m_stk[i] = m_stk[i-1];
        m_stk[0] = v;
    endtask

    function automatic logic [63:0] m_stack();
        return 64'(m_stk[3]*4096 + m_stk[2]*256 + m_stk[1]*16 + m_stk[0]);
    endfunction

    task automatic check_arch(input string tag);
        chk({tag, ".pc"},    64'(pc_out),    64'(m_pc));
        chk({tag, ".stack"}, 64'(stack_out), m_stack());
        chk({tag, ".flags"}, 64'(flags_out), 64'(m_c*2 + m_z));
        chk({tag, ".state"}, 64'(state_out), 64'd0);
    endtask

    task automatic wait_fetch(input string tag);
        int n = 0;
        while (!(state_out == 2'd0 && bus.imem_req === 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".fetch_wait"}, 64'(n < 20), 64'd1);
    endtask

    // Issue one instruction, serve its memory access after wt wait cycles,
    // then advance the model and compare architectural state.
    task automatic run(input string tag, input logic [7:0] ins, input int wt, input logic [3:0] rdv);
        int a, b, c, sel, addr, wd, n;
        bit mem, tk;
        a   = m_stk[0];
        b   = m_stk[1];
        c   = m_stk[2];
        sel = int'(ins[6:4]);
        mem = (ins[7] == 1'b0) || (ins[7:5] == 3'b100);
        addr = (sel == 0) ? b*16 + a : int'(ins[3:0]);
        case (sel)
            0:       wd = c;
            1:       wd = (a + b) % 16;
            2:       wd = (a - b + 16) % 16;
            3:       wd = a & b;
            4:       wd = a | b;
            5:       wd = a ^ b;
            6:       wd = 15 - a;
            default: wd = a;
        endcase

        wait_fetch(tag);
        chk({tag, ".imem_addr"}, 64'(bus.imem_addr), 64'(m_pc));
        bus.imem_data  = ins;
        bus.imem_valid = 1'b1;
        bus.dmem_rdata = rdv;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        bus.imem_data  = 8'($urandom);
        bus.dmem_ready = 1'($urandom_range(0, 1));   // must be ignored in EXEC
        chk({tag, ".exec"}, 64'(state_out), 64'd1);
        @(negedge clk);
        bus.dmem_ready = 1'b0;
        seen_hi = 0;
        if (mem) begin
            for (n = 0; n <= wt; n++) begin
                if (ins[7] == 1'b0) begin
                    chk({tag, ".wr"},    64'(bus.dmem_wr),    64'd1);
                    chk({tag, ".rd"},    64'(bus.dmem_rd),    64'd0);
                    chk({tag, ".wdata"}, 64'(bus.dmem_wdata), 64'(wd));
                    seen_hi += int'(bus.dmem_wr);
                end else begin
                    chk({tag, ".rd"}, 64'(bus.dmem_rd), 64'd1);
                    chk({tag, ".wr"}, 64'(bus.dmem_wr), 64'd0);
                    seen_hi += int'(bus.dmem_rd);
                end
                chk({tag, ".daddr"}, 64'(bus.dmem_addr), 64'(addr));
                seen_addr = int'(bus.dmem_addr);
                seen_wd   = int'(bus.dmem_wdata);
                bus.dmem_ready = (n == wt);
                bus.imem_valid = 1'($urandom_range(0, 1)); // must be ignored in MEM
                @(negedge clk);
            end
            bus.dmem_ready = 1'b0;
            bus.imem_valid = 1'b0;
            chk({tag, ".strobes_off"}, 64'({bus.dmem_rd, bus.dmem_wr}), 64'd0);
        end

        if (ins[7] == 1'b0) begin
            m_z = (wd == 0) ? 1 : 0;
            if (sel == 1)      m_c = (a + b > 15) ? 1 : 0;
            else if (sel == 2) m_c = (a >= b) ? 1 : 0;
            m_pc = (m_pc + 1) % 4096;
        end else if (ins[6:5] == 2'b00) begin
            m_push(int'(rdv));
            m_pc = (m_pc + 1) % 4096;
        end else if (ins[6:5] == 2'b01) begin
            m_push(int'(ins[3:0]));
            m_pc = (m_pc + 1) % 4096;
        end else begin
            case (ins[2:0])
                3'd0:    tk = 1'b1;
                3'd2:    tk = (m_c == 1);
                3'd3:    tk = (m_c == 0);
                3'd4:    tk = (m_z == 1);
                3'd5:    tk = (m_z == 0);
                default: tk = 1'b0;
            endcase
            m_pc = tk ? c*256 + b*16 + a : (m_pc + 1) % 4096;
        end
        check_arch(tag);
    endtask

    // Load on the 8-bit core, responding immediately with rdv
    task automatic run8(input logic [7:0] ins, input logic [7:0] rdv, output logic [15:0] a_seen, output logic rd_seen);
        int n = 0;
        while (bus8.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("dut8.fetch_wait", 64'(n < 20), 64'd1);
        bus8.imem_data  = ins;
        bus8.imem_valid = 1'b1;
        @(negedge clk);
        bus8.imem_valid = 1'b0;
        @(negedge clk);
        a_seen  = bus8.dmem_addr;
        rd_seen = bus8.dmem_rd;
        bus8.dmem_rdata = rdv;
        bus8.dmem_ready = 1'b1;
        @(negedge clk);
        bus8.dmem_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] a8;
        logic        r8;
        nReset = 1'b0; halt = 1'b0; halt8 = 1'b0;
        bus.imem_data = '0;  bus.imem_valid = 1'b0; bus.dmem_rdata = '0;  bus.dmem_ready = 1'b0;
        bus8.imem_data = '0; bus8.imem_valid = 1'b0; bus8.dmem_rdata = '0; bus8.dmem_ready = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst.state",    64'(state_out),    64'd0);
        chk("rst.pc",       64'(pc_out),       64'd0);
        chk("rst.stack",    64'(stack_out),    64'd0);
        chk("rst.flags",    64'(flags_out),    64'd0);
        chk("rst.strobes",  64'({bus.dmem_rd, bus.dmem_wr}), 64'd0);
        chk("rst.imem_req", 64'(bus.imem_req), 64'd0);
        nReset = 1'b1;
        @(negedge clk);

        // 3 + 5 stored to r2 with a 3-cycle wait
        run("ldi3", 8'hA3, 0, 4'h0);
        run("ldi5", 8'hA5, 0, 4'h0);
        run("add_r2", 8'h12, 3, 4'h0);
        chk("add.wr_cycles", 64'(seen_hi),   64'd4);
        chk("add.addr",      64'(seen_addr), 64'h02);
        chk("add.wdata",     64'(seen_wd),   64'd8);
        chk("add.flags",     64'(flags_out), 64'd0);

        // 9 - 9 sets zero and carry, then JZ to 0x014
        run("ldi9a", 8'hA9, 0, 4'h0);
        run("ldi9b", 8'hA9, 0, 4'h0);
        run("sub", 8'h23, 1, 4'h0);
        chk("sub.wdata", 64'(seen_wd),   64'd0);
        chk("sub.flags", 64'(flags_out), 64'b11);
        run("ldi0", 8'hA0, 0, 4'h0);
        run("ldi1", 8'hA1, 0, 4'h0);
        run("ldi4", 8'hA4, 0, 4'h0);
        run("jz", 8'hC4, 0, 4'h0);
        chk("jz.pc", 64'(pc_out), 64'h014);

        // five pushes into a 4-deep stack drop the oldest value
        for (int v = 1; v <= 5; v++) run("push", 8'(8'hA0 + v), 0, 4'h0);
        chk("push5.stack", 64'(stack_out), 64'h2345);

        // pc wrap and halt
        run("ldiF0", 8'hAF, 0, 4'h0);
        run("ldiF1", 8'hAF, 0, 4'h0);
        run("ldiF2", 8'hAF, 0, 4'h0);
        run("jp_fff", 8'hC0, 0, 4'h0);
        chk("jp.pc", 64'(pc_out), 64'hFFF);
        run("nop_wrap", 8'hC1, 0, 4'h0);
        chk("wrap.pc", 64'(pc_out), 64'h000);
        halt = 1'b1;
        bus.imem_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("halt.imem_req", 64'(bus.imem_req), 64'd0);
            chk("halt.state",    64'(state_out),    64'd0);
            chk("halt.pc",       64'(pc_out),       64'd0);
        end
        bus.imem_valid = 1'b0;
        halt = 1'b0;
        #1;
        chk("unhalt.imem_req", 64'(bus.imem_req), 64'd1);

        // random instruction stream
        repeat (80) run("rnd", 8'($urandom), int'($urandom_range(0, 3)), 4'($urandom));

        // reset during a load wait
        run("pre_rst", 8'hA7, 0, 4'h0);
        wait_fetch("rst_mid");
        bus.imem_data  = 8'h95;
        bus.imem_valid = 1'b1;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid.rd0", 64'(bus.dmem_rd), 64'd1);
        @(negedge clk);
        chk("rst_mid.rd1", 64'(bus.dmem_rd), 64'd1);
        #2 nReset = 1'b0;
        #1;
        chk("rst_mid.rd_drop", 64'(bus.dmem_rd), 64'd0);
        chk("rst_mid.pc",      64'(pc_out),      64'd0);
        chk("rst_mid.stack",   64'(stack_out),   64'd0);
        chk("rst_mid.state",   64'(state_out),   64'd0);
        @(negedge clk);
        nReset = 1'b1;
        m_reset();
        @(negedge clk);
        check_arch("post_rst");

        // 8-bit core: build B=0x12, A=0x34, then load [{B,A}]
        run8(8'h90, 8'h12, a8, r8);
        chk("dut8.ld0.addr", 64'(a8), 64'h0000);
        chk("dut8.ld0.rd",   64'(r8), 64'd1);
        run8(8'h90, 8'h34, a8, r8);
        chk("dut8.ld1.addr", 64'(a8), 64'h0000);
        run8(8'h80, 8'hA5, a8, r8);
        chk("dut8.ldab.addr", 64'(a8),     64'h1234);
        chk("dut8.ldab.rd",   64'(r8),     64'd1);
        chk("dut8.stack",     64'(stack8), 64'h1234A5);
        chk("dut8.pc",        64'(pc8),    64'd3);
        chk("dut8.flags",     64'(flags8), 64'd0);
        chk("dut8.state",     64'(state8), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
